// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: host command FIFO in front of the LCD controller.
// Pops one command at a time while the controller is idle, strobes it on
// lcd_cmd/lcd_cmd_valid and, for a Load (code 0), walks the image ROM so that
// the 108 bytes of the selected 12x9 image appear on lcd_datain back to back.
// Optional build macro: CMD_FILTER_EN -- drops host code 7 at the FIFO input
// and reports each discarded push on drop_pulse.
module lcd_cmd_seq #(
  parameter int CMD_DEPTH = 4,
  parameter int IMAGES    = 4,
  parameter int IMG_W     = 2,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        host_cmd,
  input  logic [IMG_W-1:0]  host_img,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [2:0]        lcd_cmd,
  output logic              lcd_cmd_valid,
  output logic [7:0]        lcd_datain,
  input  logic              lcd_busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              seq_idle
`ifdef CMD_FILTER_EN
  ,
  output logic              drop_pulse
`endif
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int ENT_W = 3 + IMG_W;
  localparam logic [6:0] LAST_BYTE = 7'd107;
  localparam logic [ADDR_W-1:0] IMG_BYTES = ADDR_W'(108);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_WAIT_LO = 2'd3
  } state_t;

  // command FIFO storage and bookkeeping
  logic [ENT_W-1:0]  fifo_mem_r [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              full_s;
  logic              empty_s;
  logic              keep_s;
  logic              push_s;
  logic              pop_s;

  // head-of-FIFO decode
  logic [ENT_W-1:0]  head_s;
  logic [2:0]        head_cmd_s;
  logic [IMG_W-1:0]  head_img_s;
  logic [ADDR_W-1:0] base_s;

  // sequencer state and next values
  state_t            state_r;
  state_t            state_nxt_s;
  logic [6:0]        byte_cnt_r;
  logic [6:0]        byte_cnt_nxt_s;
  logic [2:0]        lcd_cmd_nxt_s;
  logic              lcd_cmd_valid_nxt_s;
  logic [ADDR_W-1:0] rom_addr_nxt_s;

  assign full_s     = (count_r == (PTR_W+1)'(CMD_DEPTH));
  assign empty_s    = (count_r == '0);
  assign host_ready = ~full_s;

`ifdef CMD_FILTER_EN
  // code 7 would wedge the controller, so it never reaches the FIFO
  assign keep_s = (host_cmd != 3'd7);
`else
  assign keep_s = 1'b1;
`endif

  assign push_s = host_valid & host_ready & keep_s;

  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign head_cmd_s = head_s[ENT_W-1 -: 3];
  assign head_img_s = head_s[IMG_W-1:0];

  // an out-of-range image index falls back to image 0 instead of reading past the ROM
  assign base_s = ({1'b0, head_img_s} < (IMG_W+1)'(IMAGES)) ?
                  (ADDR_W'(head_img_s) * IMG_BYTES) : '0;

  assign lcd_datain = rom_data;
  assign seq_idle   = empty_s & (state_r == ST_IDLE);

  // FIFO storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {host_cmd, host_img};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef CMD_FILTER_EN
  // one-cycle flag for every accepted-but-discarded host push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= host_valid & host_ready & ~keep_s;
    end
  end
`endif

  // sequencer next-state and output decisions
  always_comb begin
    state_nxt_s         = state_r;
    byte_cnt_nxt_s      = byte_cnt_r;
    lcd_cmd_nxt_s       = lcd_cmd;
    lcd_cmd_valid_nxt_s = 1'b0;
    rom_addr_nxt_s      = rom_addr;
    pop_s               = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !lcd_busy) begin
          pop_s               = 1'b1;
          state_nxt_s         = ST_ISSUE;
          lcd_cmd_nxt_s       = head_cmd_s;
          lcd_cmd_valid_nxt_s = 1'b1;
          rom_addr_nxt_s      = base_s;
          byte_cnt_nxt_s      = 7'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (lcd_cmd == 3'd0) begin
          state_nxt_s    = ST_LOAD;
          rom_addr_nxt_s = rom_addr + ADDR_W'(1);
          byte_cnt_nxt_s = 7'd1;
        end else begin
          state_nxt_s = ST_WAIT_LO;
        end
      end
      ST_LOAD: begin
        if (byte_cnt_r == LAST_BYTE) begin
          state_nxt_s = ST_WAIT_LO;
        end else begin
          rom_addr_nxt_s = rom_addr + ADDR_W'(1);
          byte_cnt_nxt_s = byte_cnt_r + 7'd1;
        end
      end
      ST_WAIT_LO: begin
        if (!lcd_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_LO;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // sequencer registers, including the registered controller-facing outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      byte_cnt_r    <= 7'd0;
      lcd_cmd       <= 3'd0;
      lcd_cmd_valid <= 1'b0;
      rom_addr      <= '0;
    end else begin
      state_r       <= state_nxt_s;
      byte_cnt_r    <= byte_cnt_nxt_s;
      lcd_cmd       <= lcd_cmd_nxt_s;
      lcd_cmd_valid <= lcd_cmd_valid_nxt_s;
      rom_addr      <= rom_addr_nxt_s;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: directed and randomized stimulus for lcd_cmd_seq with a
// behavioural controller busy model, a synchronous image ROM and an
// expected-command queue built from what the host handshake accepted.
module tb_lcd_cmd_seq;

  localparam int CMD_DEPTH = 4;
  localparam int IMAGES    = 4;
  localparam int IMG_W     = 2;
  localparam int ADDR_W    = 9;
  localparam int IMG_BYTES = 108;
  localparam int ROM_N     = IMAGES * IMG_BYTES;
  localparam int LOG_N     = 32768;
  localparam int LOAD_BUSY = 115;

  logic              clk;
  logic              reset;
  logic [2:0]        host_cmd;
  logic [IMG_W-1:0]  host_img;
  logic              host_valid;
  logic              host_ready;
  logic [2:0]        lcd_cmd;
  logic              lcd_cmd_valid;
  logic [7:0]        lcd_datain;
  logic              lcd_busy;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              seq_idle;
`ifdef CMD_FILTER_EN
  logic              drop_pulse;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]        rom      [ROM_N];
  logic [7:0]        data_log [LOG_N];
  logic [ADDR_W-1:0] addr_log [LOG_N];
  int cyc = 0;
  int st_cyc[$];
  int st_cmd[$];
  int exp_cmd[$];
  int exp_img[$];
  int viol = 0;
  int drops = 0;
  int busy_cnt = 0;
  int fixed_dur = 0;
  logic force_busy = 1'b0;
  logic edge_busy = 1'b0;
  logic last_acc;

  lcd_cmd_seq #(
    .CMD_DEPTH(CMD_DEPTH), .IMAGES(IMAGES), .IMG_W(IMG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_img(host_img),
    .host_valid(host_valid), .host_ready(host_ready), .lcd_cmd(lcd_cmd),
    .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain), .lcd_busy(lcd_busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .seq_idle(seq_idle)
`ifdef CMD_FILTER_EN
    , .drop_pulse(drop_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous image ROM, one cycle read latency
  always @(posedge clk) rom_data <= (int'(rom_addr) < ROM_N) ? rom[int'(rom_addr)] : 8'h00;

  // busy value the DUT sees at each rising edge
  always @(posedge clk) edge_busy = lcd_busy;

  // controller model: busy rises the cycle after a strobe and lasts a fixed span
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (lcd_cmd_valid)
      busy_cnt <= (lcd_cmd == 3'd0) ? LOAD_BUSY :
                  ((fixed_dur > 0) ? fixed_dur : int'($urandom_range(3, 20)));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign lcd_busy = force_busy | (busy_cnt != 0);

  // monitor: log the ROM address and data bus per cycle and every command strobe
  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      data_log[cyc] = lcd_datain;
      addr_log[cyc] = rom_addr;
    end
    if (reset && lcd_cmd_valid) begin
      st_cyc.push_back(cyc);
      st_cmd.push_back(int'(lcd_cmd));
      if (edge_busy) viol++;
    end
`ifdef CMD_FILTER_EN
    if (drop_pulse) drops++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [IMG_W-1:0] im);
    logic keep;
    @(negedge clk); #1;
    host_cmd = c; host_img = im; host_valid = 1'b1;
    last_acc = host_ready;
    keep = 1'b1;
`ifdef CMD_FILTER_EN
    keep = (c != 3'd7);
`endif
    if (last_acc && keep) begin
      exp_cmd.push_back(int'(c));
      exp_img.push_back(int'(im));
    end
  endtask

  task automatic host_idle();
    @(negedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (seq_idle && !lcd_busy) done = 1'b1;
    end
    check("idle_timeout", done, 1);
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_cmd.delete(); exp_cmd.delete(); exp_img.delete();
  endtask

  // compare observed strobes with the model queue; loads also get their byte stream checked
  task automatic check_strobes(input string tag);
    int n, t, base, bad;
    check({tag, "_count"}, st_cmd.size(), exp_cmd.size());
    n = (st_cmd.size() < exp_cmd.size()) ? st_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_cmd"}, st_cmd[i], exp_cmd[i]);
      if (exp_cmd[i] == 0) begin
        t = st_cyc[i];
        base = exp_img[i] * IMG_BYTES;
        bad = 0;
        for (int k = 0; k < IMG_BYTES; k++) begin
          if (t + 1 + k < LOG_N) begin
            if (data_log[t + 1 + k] !== rom[base + k]) bad++;
            if (int'(addr_log[t + k]) != base + k) bad++;
          end
        end
        check({tag, "_base"}, addr_log[t], base);
        check({tag, "_stream_bad"}, bad, 0);
      end
    end
    check({tag, "_busy_viol"}, viol, 0);
    clear_logs();
  endtask

  initial begin
    int t;
    logic acc [CMD_DEPTH+1];
    logic [2:0] rc;

    reset = 1'b0; host_valid = 1'b0; host_cmd = 3'd0; host_img = '0;
    foreach (rom[i]) rom[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    #1;
    check("rst_lcd_cmd", lcd_cmd, 0);
    check("rst_valid", lcd_cmd_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_host_ready", host_ready, 1);
    check("rst_seq_idle", seq_idle, 1);
    reset = 1'b1;

    // single load of image 1
    push(3'd0, 2'd1); host_idle();
    wait_idle(400);
    check_strobes("t1");

    // three non-load commands with a fixed 17-cycle busy span
    fixed_dur = 17;
    push(3'd1, 2'($urandom)); push(3'd3, 2'($urandom)); push(3'd4, 2'($urandom)); host_idle();
    wait_idle(400);
    for (int i = 0; i + 1 < st_cyc.size(); i++)
      check("t2_gap_ok", (st_cyc[i+1] - st_cyc[i]) >= 19, 1);
    check_strobes("t2");
    fixed_dur = 0;

    // FIFO full while busy is held high
    force_busy = 1'b1;
    for (int i = 0; i <= CMD_DEPTH; i++) begin
      push(3'($urandom_range(1, 6)), 2'($urandom));
      acc[i] = last_acc;
    end
    host_idle();
    for (int i = 0; i <= CMD_DEPTH; i++) check("t3_accept", acc[i], (i < CMD_DEPTH) ? 1 : 0);
    check("t3_full_ready", host_ready, 0);
    repeat (5) @(negedge clk);
    #1;
    check("t3_no_strobe", st_cmd.size(), 0);
    force_busy = 1'b0;
    wait_idle(600);
    check_strobes("t3");

    // reset in the middle of a load, then a fresh load
    push(3'd0, 2'd2); host_idle();
    t = -1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      @(negedge clk); #1;
      if (st_cyc.size() > 0) t = st_cyc[0];
    end
    check("t4_strobe_seen", t >= 0, 1);
    push(3'd1, 2'd0); host_idle();
    for (int i = 0; i < 200 && cyc < t + 51; i++) begin
      @(negedge clk); #1;
    end
    check("t4_byte50", data_log[cyc], rom[2*IMG_BYTES + 50]);
    reset = 1'b0;
    @(negedge clk); #1;
    check("t4_lcd_cmd", lcd_cmd, 0);
    check("t4_valid", lcd_cmd_valid, 0);
    check("t4_rom_addr", rom_addr, 0);
    check("t4_host_ready", host_ready, 1);
    check("t4_seq_idle", seq_idle, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    clear_logs();
    push(3'd0, 2'($urandom)); host_idle();
    wait_idle(400);
    check_strobes("t4");

    // code 7 handling
    drops = 0;
`ifdef CMD_FILTER_EN
    push(3'd7, 2'd0); push(3'd2, 2'd0); host_idle();
    wait_idle(400);
    check("t5_drops", drops, 1);
`else
    push(3'd7, 2'd0); host_idle();
    wait_idle(400);
`endif
    check_strobes("t5");

    // randomized command mix with random gaps and busy spans
    for (int r = 0; r < 10; r++) begin
      rc = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 6));
      push(rc, 2'($urandom));
      if ($urandom_range(0, 1) == 1) host_idle();
    end
    host_idle();
    wait_idle(4000);
    check_strobes("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
